// File: rtl/sid_pkg.sv
// Shared types and constants for the SID register write path.
package sid_pkg;

    localparam int unsigned SID_ADDR_W   = 5;
    localparam int unsigned SID_NUM_REGS = 25;
    localparam logic [SID_ADDR_W-1:0] SID_LAST_REG = 5'h18;

    typedef struct packed {
        logic [SID_ADDR_W-1:0] addr;
        logic [7:0]            data;
    } sid_wr_t;

endpackage

// File: rtl/sid_wrq_fifo.sv
// Synchronous FIFO for queued SID register writes; caller qualifies push/pop.
module sid_wrq_fifo
    import sid_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter type         entry_t = sid_wr_t,
    localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           n_reset,
    input  logic           push,
    input  logic           pop,
    input  logic           flush,
    input  entry_t         wr_entry,
    output entry_t         rd_entry,
    output logic [PTR_W:0] level,
    output logic           full,
    output logic           empty
);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q, level_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + (PTR_W+1)'(1);
                2'b01:   level_d = level_q - (PTR_W+1)'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset; level gates every read.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr_q] <= wr_entry;
    end

    assign rd_entry = mem[rd_ptr_q];
    assign level    = level_q;
    assign full     = (level_q == (PTR_W+1)'(DEPTH));
    assign empty    = (level_q == '0);

endmodule

// File: rtl/sid_wr_queue.sv
// Buffers host SID register writes and replays them as rate-limited clk_en-aligned strobes.
// Define SID_WRQ_SHADOW_EN to add a readable shadow of the last value strobed to each register.
module sid_wr_queue
    import sid_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned GAP     = 1,
    localparam int unsigned LEVEL_W = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  clk_en,
    input  logic                  host_we,
    input  logic [SID_ADDR_W-1:0] host_addr,
    input  logic [7:0]            host_data,
    output logic                  host_ready,
    input  logic                  flush,
    output logic [SID_ADDR_W-1:0] sid_addr,
    output logic [7:0]            sid_data,
    output logic                  sid_n_cs,
    output logic                  sid_rw,
    output logic [LEVEL_W-1:0]    level,
    output logic                  overflow
`ifdef SID_WRQ_SHADOW_EN
   ,input  logic [SID_ADDR_W-1:0] host_raddr,
    output logic [7:0]            host_rdata
`endif
);

    localparam logic [7:0] GAP_LOAD = 8'(GAP - 1);

    sid_wr_t               head;
    logic                  full, empty, addr_ok, push, pop;
    logic [7:0]            gap_q;
    logic                  n_cs_q, overflow_q;
    logic [SID_ADDR_W-1:0] addr_q;
    logic [7:0]            data_q;

    // Pop uses the registered level, so a fresh push never falls through in its own cycle.
    assign addr_ok    = (host_addr <= SID_LAST_REG);
    assign pop        = clk_en && !empty && (gap_q == '0) && !flush;
    assign push       = host_we && addr_ok && (!full || pop) && !flush;
    assign host_ready = !full || pop;

    sid_wrq_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (sid_wr_t)
    ) u_fifo (
        .clk      (clk),
        .n_reset  (n_reset),
        .push     (push),
        .pop      (pop),
        .flush    (flush),
        .wr_entry ('{addr: host_addr, data: host_data}),
        .rd_entry (head),
        .level    (level),
        .full     (full),
        .empty    (empty)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            n_cs_q     <= 1'b1;
            addr_q     <= '0;
            data_q     <= '0;
            gap_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            n_cs_q <= !pop;
            if (pop) begin
                addr_q <= head.addr;
                data_q <= head.data;
            end
            if (flush)                       gap_q <= '0;
            else if (pop)                    gap_q <= GAP_LOAD;
            else if (clk_en && gap_q != '0)  gap_q <= gap_q - 8'd1;
            if (flush)                                      overflow_q <= 1'b0;
            else if (host_we && addr_ok && full && !pop)    overflow_q <= 1'b1;
        end
    end

    assign sid_addr = addr_q;
    assign sid_data = data_q;
    assign sid_n_cs = n_cs_q;
    assign sid_rw   = n_cs_q;
    assign overflow = overflow_q;

`ifdef SID_WRQ_SHADOW_EN
    logic [7:0] shadow_q [SID_NUM_REGS];
    logic [7:0] rdata_q;

    // Shadow tracks what the SID actually received, hence written on pop rather than push.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < SID_NUM_REGS; i++) shadow_q[i] <= '0;
            rdata_q <= '0;
        end else begin
            if (pop) shadow_q[head.addr] <= head.data;
            rdata_q <= (host_raddr <= SID_LAST_REG) ? shadow_q[host_raddr] : 8'h00;
        end
    end

    assign host_rdata = rdata_q;
`endif

endmodule

// File: tb/tb_sid_wr_queue.sv
// Scoreboard bench for sid_wr_queue (DEPTH=16, GAP=3); shadow checks when SID_WRQ_SHADOW_EN is set.
module tb_sid_wr_queue;
    import sid_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned GAP   = 3;

    logic       clk = 1'b0, n_reset = 1'b0, clk_en = 1'b0, host_we = 1'b0, flush = 1'b0;
    logic [4:0] host_addr = '0;
    logic [7:0] host_data = '0;
    logic       host_ready, sid_n_cs, sid_rw, overflow;
    logic [4:0] sid_addr;
    logic [7:0] sid_data;
    logic [4:0] level;
`ifdef SID_WRQ_SHADOW_EN
    logic [4:0] host_raddr = '0;
    logic [7:0] host_rdata;
`endif

    sid_wr_queue #(
        .DEPTH (DEPTH),
        .GAP   (GAP)
    ) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .clk_en     (clk_en),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_data  (host_data),
        .host_ready (host_ready),
        .flush      (flush),
        .sid_addr   (sid_addr),
        .sid_data   (sid_data),
        .sid_n_cs   (sid_n_cs),
        .sid_rw     (sid_rw),
        .level      (level),
        .overflow   (overflow)
`ifdef SID_WRQ_SHADOW_EN
       ,.host_raddr (host_raddr),
        .host_rdata (host_rdata)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          errors = 0, checks = 0;
    int          en_period = 0;
    int          strobe_cnt = 0;
    int          strobe_log [$];
    logic [12:0] exp_q [$];
    bit          prev_low = 1'b0;
    int          base, push_cyc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs change 1 time unit after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
        clk_en = (en_period != 0) && (cyc % en_period == 0);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic write(input logic [4:0] a, input logic [7:0] d, input bit expect_store);
        host_we   = 1'b1;
        host_addr = a;
        host_data = d;
        if (expect_store) exp_q.push_back({a, d});
        step();
        host_we = 1'b0;
    endtask

    task automatic wait_strobes(input int target, input int budget);
        int k = 0;
        while (strobe_cnt < target && k < budget) begin
            step();
            k++;
        end
        check_eq("strobe_timeout", 32'(strobe_cnt >= target), 32'd1);
    endtask

    // Strobe monitor: order, content and single-cycle width against the scoreboard.
    always @(negedge clk) begin
        if (n_reset) begin
            if (!sid_n_cs) begin
                strobe_cnt++;
                strobe_log.push_back(cyc);
                check_eq("strobe_rw", 32'(sid_rw), 32'd0);
                check_eq("strobe_single", 32'(prev_low), 32'd0);
                check_eq("strobe_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check_eq("strobe_data", 32'({sid_addr, sid_data}),
                                                 32'(exp_q.pop_front()));
            end else if (prev_low) begin
                check_eq("rw_release", 32'(sid_rw), 32'd1);
            end
            prev_low = !sid_n_cs;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 n_reset = 1'b1;
        @(negedge clk);
        check_eq("rst_n_cs", 32'(sid_n_cs), 32'd1);
        check_eq("rst_rw", 32'(sid_rw), 32'd1);
        check_eq("rst_addr", 32'(sid_addr), 32'd0);
        check_eq("rst_data", 32'(sid_data), 32'd0);
        check_eq("rst_ready", 32'(host_ready), 32'd1);
        check_eq("rst_level", 32'(level), 32'd0);
        check_eq("rst_overflow", 32'(overflow), 32'd0);

        // Single write, clk_en tied high: strobe one cycle after the push edge.
        en_period = 1;
        step();
        write(5'h18, 8'h0F, 1'b1);
        push_cyc = cyc;
        wait_strobes(1, 10);
        check_eq("latency", 32'(strobe_log.size() > 0 ? strobe_log[0] - push_cyc : 0), 32'd1);
        idle(3);
        @(negedge clk);
        check_eq("lat_level", 32'(level), 32'd0);
        check_eq("lat_count", 32'(strobe_cnt), 32'd1);

        // GAP=3 with clk_en every 4th clk: strobes 12 clk apart.
        idle(6);
        strobe_log.delete();
        en_period = 4;
        base = strobe_cnt;
        write(5'h00, 8'h11, 1'b1);
        write(5'h01, 8'h22, 1'b1);
        write(5'h04, 8'h44, 1'b1);
        wait_strobes(base + 3, 60);
        check_eq("gap_count", 32'(strobe_log.size()), 32'd3);
        if (strobe_log.size() == 3) begin
            check_eq("gap_1", 32'(strobe_log[1] - strobe_log[0]), 32'd12);
            check_eq("gap_2", 32'(strobe_log[2] - strobe_log[1]), 32'd12);
        end

        // Fill with clk_en off, overflow on the 17th write, then drain.
        idle(16);
        en_period = 0;
        step();
        base = strobe_cnt;
        for (int i = 0; i < 17; i++) write(5'(i), 8'(8'h30 + i), i < 16);
        @(negedge clk);
        check_eq("full_level", 32'(level), 32'd16);
        check_eq("full_ready", 32'(host_ready), 32'd0);
        check_eq("full_overflow", 32'(overflow), 32'd1);
        check_eq("full_nostrobe", 32'(strobe_cnt), 32'(base));
        en_period = 4;
        wait_strobes(base + 16, 16 * 12 + 20);
        idle(2);
        @(negedge clk);
        check_eq("drain_sb", 32'(exp_q.size()), 32'd0);
        check_eq("drain_level", 32'(level), 32'd0);
        check_eq("drain_overflow", 32'(overflow), 32'd1);
        en_period = 0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        @(negedge clk);
        check_eq("flush_overflow", 32'(overflow), 32'd0);

        // Full FIFO with a simultaneous push and pop.
        base = strobe_cnt;
        for (int i = 0; i < 16; i++) write(5'(i), 8'(8'h80 + i), 1'b1);
        @(negedge clk);
        check_eq("refill_ready", 32'(host_ready), 32'd0);
        step();
        clk_en    = 1'b1;
        host_we   = 1'b1;
        host_addr = 5'h10;
        host_data = 8'hEE;
        exp_q.push_back({5'h10, 8'hEE});
        @(negedge clk);
        check_eq("pp_ready", 32'(host_ready), 32'd1);
        step();
        host_we = 1'b0;
        @(negedge clk);
        check_eq("pp_level", 32'(level), 32'd16);
        check_eq("pp_overflow", 32'(overflow), 32'd0);
        en_period = 4;
        wait_strobes(base + 17, 17 * 12 + 30);
        idle(2);
        check_eq("pp_sb", 32'(exp_q.size()), 32'd0);

        // Out-of-range address is dropped silently.
        idle(16);
        en_period = 1;
        base = strobe_cnt;
        write(5'h1F, 8'h55, 1'b0);
        idle(5);
        @(negedge clk);
        check_eq("bad_level", 32'(level), 32'd0);
        check_eq("bad_overflow", 32'(overflow), 32'd0);
        check_eq("bad_nostrobe", 32'(strobe_cnt), 32'(base));

        // Flush while a strobe is out and five entries remain queued.
        en_period = 0;
        step();
        base = strobe_cnt;
        for (int i = 0; i < 6; i++) write(5'(8 + i), 8'(8'h60 + i), i == 0);
        clk_en = 1'b1;
        step();
        flush = 1'b1;
        @(negedge clk);
        check_eq("fl_strobe", 32'(sid_n_cs), 32'd0);
        check_eq("fl_level5", 32'(level), 32'd5);
        step();
        flush = 1'b0;
        @(negedge clk);
        check_eq("fl_level0", 32'(level), 32'd0);
        check_eq("fl_n_cs", 32'(sid_n_cs), 32'd1);
        en_period = 1;
        idle(20);
        check_eq("fl_count", 32'(strobe_cnt), 32'(base + 1));
        check_eq("fl_sb", 32'(exp_q.size()), 32'd0);

`ifdef SID_WRQ_SHADOW_EN
        base = strobe_cnt;
        write(5'h05, 8'hA9, 1'b1);
        wait_strobes(base + 1, 20);
        host_raddr = 5'h05;
        step();
        @(negedge clk);
        check_eq("shadow_05", 32'(host_rdata), 32'hA9);
        host_raddr = 5'h1A;
        step();
        @(negedge clk);
        check_eq("shadow_1a", 32'(host_rdata), 32'h00);
        host_raddr = 5'h18;
        step();
        @(negedge clk);
        check_eq("shadow_18", 32'(host_rdata), 32'h0F);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sid_wr_queue.md
Name: sid_wr_queue

Overview:
- Upstream feeder for the SID core's register write port.
- Accepts host (Z80/bridge) register writes at arbitrary clk cycles and buffers them in a FIFO.
- Replays them onto the SID bus (addr/data/n_cs/rw) as single-clk write strobes, aligned to the SID clk_en tick and rate-limited.
- Decouples bursty CPU register updates from the SID voice/filter timing.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, minimum 2.
- GAP, 1, minimum number of clk_en ticks between consecutive SID strobes; range 1..255.

Ports:
- clk  in  1  system clock.
- n_reset  in  1  asynchronous, active-low reset.
- clk_en  in  1  SID tick; same signal that drives the SID core.
- host_we  in  1  host write request, one entry per cycle high.
- host_addr  in  5  SID register address.
- host_data  in  8  register value.
- host_ready  out  1  FIFO not full.
- flush  in  1  synchronous FIFO clear.
- sid_addr  out  5  to SID addr.
- sid_data  out  8  to SID data.
- sid_n_cs  out  1  to SID n_cs; low for exactly one clk per write.
- sid_rw  out  1  to SID rw; low together with sid_n_cs, else high.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky flag: a write was dropped because the FIFO was full.

Behaviour:
- Reset values: sid_n_cs=1, sid_rw=1, sid_addr=0, sid_data=0, host_ready=1, level=0, overflow=0, gap counter=0, pointers=0.
- Push condition: host_we && host_addr<=5'h18 && !full.
  - Entry stored in the same cycle; level increments at the next edge.
- Addresses 5'h19..5'h1F are discarded silently: not stored, no overflow.
- host_we while full: entry dropped, overflow set to 1. overflow clears only on reset or flush.
- Pop condition, evaluated on an edge where all of the following hold: clk_en=1, level>0 (registered count, so no same-cycle fall-through), gap counter==0, flush=0.
- On pop:
  - Register sid_addr/sid_data from the FIFO head.
  - Drive sid_n_cs=0 and sid_rw=0 for exactly the next clk cycle.
  - Load the gap counter with GAP-1.
- Strobe deassertion: sid_n_cs and sid_rw return to 1 on the following edge regardless of clk_en. sid_addr/sid_data hold their last values.
- Gap counter decrements on each clk_en while nonzero. With GAP=1 a pop is possible on every clk_en.
- Latency: a push at edge t into an empty FIFO with clk_en permanently high gives pop at edge t+1 and strobe visible during cycle t+1..t+2.
- Simultaneous push and pop: both occur; level unchanged; order preserved. This also applies when full, because the pop frees a slot in the same cycle; host_ready is computed as !full || pop_this_cycle.
- Flush:
  - Pointers and level go to 0, overflow clears, gap counter clears.
  - A strobe already asserted completes its single cycle.
  - A push in the flush cycle is discarded.
- Pointer arithmetic: $clog2(DEPTH)-bit pointers wrap naturally. level ranges 0..DEPTH.
- Reset mid-strobe: outputs go to reset values immediately (asynchronous).

Optional Feature:
- Macro: SID_WRQ_SHADOW_EN.
- When defined:
  - Adds a 25x8 shadow register file, written at SID strobe time (not at push time).
  - Adds ports host_raddr in 5 and host_rdata out 8. host_rdata is registered with 1-cycle latency and returns the last value strobed to that register. Addresses >0x18 read 8'h00.
  - Shadow resets to 0; flush does not clear it.
- When undefined: no shadow storage and no read ports.

Decomposition:
- Package sid_pkg:
  - SID_ADDR_W=5, SID_NUM_REGS=25, SID_LAST_REG=5'h18.
  - typedef struct sid_wr_t {addr[4:0], data[7:0]} used for FIFO entries.
- Sub-module sid_wrq_fifo: synchronous FIFO storage, pointers, level, full/empty; parameterised by DEPTH and entry type.
- Top level contains the strobe generator, gap counter, address filter and optional shadow.

Test Plan:
- Reset, then push (0x18, 0x0F) with clk_en tied high -> single strobe one cycle later with sid_addr=0x18, sid_data=0x0F, sid_n_cs low for exactly 1 clk; level returns to 0.
- GAP=3, clk_en every 4th clk, push 3 writes back-to-back -> strobes spaced 12 clk apart, in order 0x00,0x01,0x04.
- DEPTH=16, clk_en=0, push 17 writes -> level=16, host_ready=0, overflow=1. Then enable clk_en -> exactly the first 16 values emerge.
- Full FIFO with simultaneous push and pop -> level stays 16, no overflow, new entry emerges last.
- Push to address 0x1F -> no strobe, level 0, overflow 0. Flush with level=5 mid-strobe -> current strobe completes, level=0, no further strobes.
- SID_WRQ_SHADOW_EN: push (0x05, 0xA9) and wait for the strobe, then read 0x05 -> host_rdata=0xA9 one cycle later. Read 0x1A -> 0x00.
